// File: rtl/icache_pkg.sv
// Shared types and helpers for the set-associative instruction cache:
// FSM states, kseg1 segment code, address split and pseudo-LRU functions.
package icache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REFILL,
    S_RESP,
    S_UNC,
    S_INV
  } state_e;

  localparam logic [2:0] UNC_SEG = 3'b101;

  function automatic logic [31:0] addr_tag(
    input logic [31:0] a,
    input int          iw,
    input int          ow
  );
    return a >> (iw + ow);
  endfunction

  function automatic logic [31:0] addr_index(
    input logic [31:0] a,
    input int          iw,
    input int          ow
  );
    return (a >> ow) & ((32'd1 << iw) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_word(
    input logic [31:0] a,
    input int          ow
  );
    return (a >> 2) & ((32'd1 << (ow - 2)) - 32'd1);
  endfunction

  // State bits name the next victim. 4-way tree: bit 0 picks the pair
  // (1 = ways 2/3), bit 1 the way inside 0/1, bit 2 inside 2/3.
  function automatic logic [2:0] plru_touch(
    input logic [2:0] s,
    input logic [1:0] w,
    input int         ways
  );
    logic [2:0] n;
    n = s;
    if (ways == 2) begin
      n[0] = ~w[0];
    end else if (ways == 4) begin
      n[0] = ~w[1];
      if (w[1]) n[2] = ~w[0];
      else      n[1] = ~w[0];
    end
    return n;
  endfunction

  function automatic logic [1:0] plru_victim(
    input logic [2:0] s,
    input int         ways
  );
    logic [1:0] v;
    v = 2'd0;
    if (ways == 2) begin
      v = {1'b0, s[0]};
    end else if (ways == 4) begin
      v = s[0] ? {1'b1, s[2]} : {1'b0, s[1]};
    end
    return v;
  endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: valid bits (reset), tag and line arrays (not reset).
// Ports: combinational read by index, per-set clear, full-line write.
module icache_way
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH = 7,
  parameter int TAG_WIDTH   = 21,
  parameter int LINE_WORDS  = 4
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [INDEX_WIDTH-1:0]           rd_index,
  output logic                             rd_valid,
  output logic [TAG_WIDTH-1:0]             rd_tag,
  output logic [LINE_WORDS-1:0][31:0]      rd_line,
  input  logic                             clr_en,
  input  logic [INDEX_WIDTH-1:0]           clr_index,
  input  logic                             wr_en,
  input  logic [INDEX_WIDTH-1:0]           wr_index,
  input  logic [TAG_WIDTH-1:0]             wr_tag,
  input  logic                             wr_valid,
  input  logic [LINE_WORDS-1:0][31:0]      wr_line
);

  localparam int SETS = 1 << INDEX_WIDTH;

  logic [SETS-1:0]                 valid_q;
  logic [TAG_WIDTH-1:0]            tag_q  [SETS];
  logic [LINE_WORDS-1:0][31:0]     data_q [SETS];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
    end else if (clr_en) begin
      valid_q[clr_index] <= 1'b0;
    end else if (wr_en) begin
      valid_q[wr_index] <= wr_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];

endmodule

// File: rtl/icache_set_assoc.sv
// N-way set-associative I-cache with PLRU, line refill over sram-like bus,
// kseg1 bypass and invalidate-all sweep. CPU side in, bus side out.
module icache_set_assoc
  import icache_pkg::*;
#(
  parameter int WAYS         = 2,
  parameter int INDEX_WIDTH  = 7,
  parameter int OFFSET_WIDTH = 4,
  parameter int UNCACHED_EN  = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_inst_req,
  input  logic        cpu_inst_wr,
  input  logic [1:0]  cpu_inst_size,
  input  logic [31:0] cpu_inst_addr,
  input  logic [31:0] cpu_inst_wdata,
  output logic [31:0] cpu_inst_rdata,
  output logic        cpu_inst_addr_ok,
  output logic        cpu_inst_data_ok,
  input  logic        inv_req,
  output logic        inv_done,
  output logic        cache_inst_req,
  output logic        cache_inst_wr,
  output logic [1:0]  cache_inst_size,
  output logic [31:0] cache_inst_addr,
  output logic [31:0] cache_inst_wdata,
  input  logic [31:0] cache_inst_rdata,
  input  logic        cache_inst_addr_ok,
  input  logic        cache_inst_data_ok
);

  localparam int SETS       = 1 << INDEX_WIDTH;
  localparam int BW         = OFFSET_WIDTH - 2;
  localparam int LINE_WORDS = 1 << BW;
  localparam int TAG_W      = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LRU_W      = (WAYS == 4) ? 3 : 1;

  state_e                     state_q, state_d;
  logic [31:0]                addr_q, addr_d;
  logic [WAY_W-1:0]           victim_q, victim_d;
  logic [BW:0]                beat_q, beat_d;
  logic                       pend_q, pend_d;
  logic [INDEX_WIDTH-1:0]     inv_cnt_q, inv_cnt_d;
  logic [LINE_WORDS-1:0][31:0] line_q;
  logic [LRU_W-1:0]           lru_q [SETS];

  logic [INDEX_WIDTH-1:0]     cpu_idx, q_idx;
  logic [TAG_W-1:0]           cpu_tag, q_tag;
  logic [BW-1:0]              cpu_word, q_word;
  logic                       is_unc;

  logic [WAYS-1:0]            way_valid;
  logic [TAG_W-1:0]           way_tag  [WAYS];
  logic [LINE_WORDS-1:0][31:0] way_line [WAYS];

  logic                       hit;
  logic [WAY_W-1:0]           hit_way;
  logic [31:0]                hit_word;
  logic [WAY_W-1:0]           vic;

  logic                       lb_we;
  logic                       way_we;
  logic                       inv_clr;
  logic                       lru_we;
  logic [INDEX_WIDTH-1:0]     lru_idx;
  logic [LRU_W-1:0]           lru_val;

  assign cpu_idx  = INDEX_WIDTH'(addr_index(cpu_inst_addr, INDEX_WIDTH, OFFSET_WIDTH));
  assign cpu_tag  = TAG_W'(addr_tag(cpu_inst_addr, INDEX_WIDTH, OFFSET_WIDTH));
  assign cpu_word = BW'(addr_word(cpu_inst_addr, OFFSET_WIDTH));
  assign q_idx    = INDEX_WIDTH'(addr_index(addr_q, INDEX_WIDTH, OFFSET_WIDTH));
  assign q_tag    = TAG_W'(addr_tag(addr_q, INDEX_WIDTH, OFFSET_WIDTH));
  assign q_word   = BW'(addr_word(addr_q, OFFSET_WIDTH));
  assign is_unc   = (UNCACHED_EN != 0) && (cpu_inst_addr[31:29] == UNC_SEG);

  assign cache_inst_wr    = 1'b0;
  assign cache_inst_size  = 2'b10;
  assign cache_inst_wdata = 32'd0;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(
      .INDEX_WIDTH (INDEX_WIDTH),
      .TAG_WIDTH   (TAG_W),
      .LINE_WORDS  (LINE_WORDS)
    ) u_way (
      .clk       (clk),
      .resetn    (resetn),
      .rd_index  (cpu_idx),
      .rd_valid  (way_valid[w]),
      .rd_tag    (way_tag[w]),
      .rd_line   (way_line[w]),
      .clr_en    (inv_clr),
      .clr_index (inv_cnt_q),
      .wr_en     (way_we && (victim_q == WAY_W'(w))),
      .wr_index  (q_idx),
      .wr_tag    (q_tag),
      .wr_valid  (1'b1),
      .wr_line   (line_q)
    );
  end

  // Lookup plus victim choice: lowest invalid way wins over PLRU.
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    hit_word = 32'd0;
    vic      = WAY_W'(plru_victim(3'(lru_q[cpu_idx]), WAYS));
    for (int w = 0; w < WAYS; w++) begin
      if (way_valid[w] && (way_tag[w] == cpu_tag)) begin
        hit      = 1'b1;
        hit_way  = WAY_W'(w);
        hit_word = way_line[w][cpu_word];
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) vic = WAY_W'(w);
    end
  end

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    victim_d         = victim_q;
    beat_d           = beat_q;
    pend_d           = pend_q;
    inv_cnt_d        = inv_cnt_q;
    lb_we            = 1'b0;
    way_we           = 1'b0;
    inv_clr          = 1'b0;
    lru_we           = 1'b0;
    lru_idx          = cpu_idx;
    lru_val          = LRU_W'(plru_touch(3'(lru_q[cpu_idx]), 2'(hit_way), WAYS));
    cpu_inst_addr_ok = 1'b0;
    cpu_inst_data_ok = 1'b0;
    cpu_inst_rdata   = 32'd0;
    cache_inst_req   = 1'b0;
    cache_inst_addr  = 32'd0;
    inv_done         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (inv_req) begin
          state_d   = S_INV;
          inv_cnt_d = '0;
        end else if (cpu_inst_req) begin
          cpu_inst_addr_ok = 1'b1;
          addr_d           = cpu_inst_addr;
          pend_d           = 1'b0;
          if (is_unc) begin
            state_d = S_UNC;
          end else if (hit) begin
            cpu_inst_data_ok = 1'b1;
            cpu_inst_rdata   = hit_word;
            lru_we           = 1'b1;
          end else begin
            victim_d = vic;
            beat_d   = '0;
            state_d  = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        if (beat_q[BW]) begin
          // Whole line buffered: commit it to the victim way.
          way_we  = 1'b1;
          lru_we  = 1'b1;
          lru_idx = q_idx;
          lru_val = LRU_W'(plru_touch(3'(lru_q[q_idx]), 2'(victim_q), WAYS));
          state_d = S_RESP;
        end else begin
          cache_inst_req  = !pend_q;
          cache_inst_addr = {addr_q[31:OFFSET_WIDTH], beat_q[BW-1:0], 2'b00};
          if (!pend_q && cache_inst_addr_ok) pend_d = 1'b1;
          if (pend_q && cache_inst_data_ok) begin
            lb_we  = 1'b1;
            beat_d = beat_q + 1'b1;
            pend_d = 1'b0;
          end
        end
      end
      S_RESP: begin
        cpu_inst_data_ok = 1'b1;
        cpu_inst_rdata   = line_q[q_word];
        state_d          = S_IDLE;
      end
      S_UNC: begin
        cache_inst_req  = !pend_q;
        cache_inst_addr = addr_q;
        if (!pend_q && cache_inst_addr_ok) pend_d = 1'b1;
        if (pend_q && cache_inst_data_ok) begin
          cpu_inst_data_ok = 1'b1;
          cpu_inst_rdata   = cache_inst_rdata;
          pend_d           = 1'b0;
          state_d          = S_IDLE;
        end
      end
      S_INV: begin
        inv_clr   = 1'b1;
        inv_cnt_d = inv_cnt_q + 1'b1;
        if (&inv_cnt_q) begin
          inv_done = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      addr_q    <= 32'd0;
      victim_q  <= '0;
      beat_q    <= '0;
      pend_q    <= 1'b0;
      inv_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      victim_q  <= victim_d;
      beat_q    <= beat_d;
      pend_q    <= pend_d;
      inv_cnt_q <= inv_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < SETS; s++) lru_q[s] <= '0;
    end else if (inv_clr) begin
      lru_q[inv_cnt_q] <= '0;
    end else if (lru_we) begin
      lru_q[lru_idx] <= lru_val;
    end
  end

  always_ff @(posedge clk) begin
    if (lb_we) line_q[beat_q[BW-1:0]] <= cache_inst_rdata;
  end

endmodule

// File: tb/tb_icache_set_assoc.sv
// Directed bench for icache_set_assoc (WAYS=2, 128 sets, 4-word lines).
// Bus model returns data equal to the word address.
module tb_icache_set_assoc;

  localparam int SETS = 128;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = 32'd0;
  logic        inv_req = 1'b0;
  logic [31:0] cpu_rdata;
  logic        cpu_aok, cpu_dok, inv_done;
  logic        c_req, c_wr;
  logic [1:0]  c_size;
  logic [31:0] c_addr, c_wdata;
  logic [31:0] bus_rdata = 32'd0;
  logic        bus_aok = 1'b0, bus_dok = 1'b0;

  int aok_dly = 0, dok_dly = 1;
  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int cpu_dok_cnt = 0, last_bus_dok_cyc = -1;
  int req_run = 0, run_min = 999, run_max = 0, req_while_pend = 0;
  bit outst = 1'b0;
  logic [31:0] bus_log [$];

  always #5 clk = ~clk;

  icache_set_assoc dut (
    .clk                (clk),
    .resetn             (resetn),
    .cpu_inst_req       (cpu_req),
    .cpu_inst_wr        (1'b0),
    .cpu_inst_size      (2'b10),
    .cpu_inst_addr      (cpu_addr),
    .cpu_inst_wdata     (32'd0),
    .cpu_inst_rdata     (cpu_rdata),
    .cpu_inst_addr_ok   (cpu_aok),
    .cpu_inst_data_ok   (cpu_dok),
    .inv_req            (inv_req),
    .inv_done           (inv_done),
    .cache_inst_req     (c_req),
    .cache_inst_wr      (c_wr),
    .cache_inst_size    (c_size),
    .cache_inst_addr    (c_addr),
    .cache_inst_wdata   (c_wdata),
    .cache_inst_rdata   (bus_rdata),
    .cache_inst_addr_ok (bus_aok),
    .cache_inst_data_ok (bus_dok)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples 2ns before each rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (cpu_dok) cpu_dok_cnt++;
      if (bus_dok) last_bus_dok_cyc = cyc;
      if (c_req && outst) req_while_pend++;
      if (c_req) req_run++;
      if (c_req && bus_aok) begin
        bus_log.push_back(c_addr);
        if (req_run < run_min) run_min = req_run;
        if (req_run > run_max) run_max = req_run;
        req_run = 0;
        outst = 1'b1;
      end else if (!c_req) begin
        req_run = 0;
      end
      if (bus_dok) outst = 1'b0;
    end
  end

  // Bus slave: addr_ok after aok_dly cycles, data_ok dok_dly cycles later.
  initial begin
    logic [31:0] baddr;
    forever begin
      @(negedge clk);
      bus_aok = 1'b0;
      bus_dok = 1'b0;
      if (c_req) begin
        for (int i = 0; i < aok_dly; i++) @(negedge clk);
        bus_aok = 1'b1;
        baddr = c_addr;
        @(negedge clk);
        bus_aok = 1'b0;
        for (int i = 1; i < dok_dly; i++) @(negedge clk);
        bus_dok = 1'b1;
        bus_rdata = baddr;
      end
    end
  end

  task automatic fetch(input logic [31:0] a, output logic [31:0] d,
                       output bit same, output int dcyc);
    int n;
    bit ok;
    d = 32'd0;
    same = 1'b0;
    dcyc = -1;
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_addr = a;
    n = 0;
    ok = 1'b0;
    while (n < 100 && !ok) begin
      #3;
      if (cpu_aok) ok = 1'b1;
      else begin
        n++;
        @(negedge clk);
      end
    end
    if (!ok) begin
      check("aok_timeout", 32'(ok), 32'd1);
      cpu_req = 1'b0;
      return;
    end
    same = cpu_dok;
    d = cpu_rdata;
    dcyc = cyc;
    @(negedge clk);
    cpu_req = 1'b0;
    cpu_addr = 32'h0000_0040;
    if (!same) begin
      n = 0;
      ok = 1'b0;
      while (n < 400 && !ok) begin
        #3;
        if (cpu_dok) begin
          ok = 1'b1;
          d = cpu_rdata;
          dcyc = cyc;
        end else begin
          n++;
          @(negedge clk);
        end
      end
      if (!ok) check("dok_timeout", 32'(ok), 32'd1);
    end
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] a;
    bit same;
    int dc, b0, k0, c0, n, bad;
    bit done;

    repeat (3) @(negedge clk);
    #3;
    check("rst_aok", 32'(cpu_aok), 32'd0);
    check("rst_dok", 32'(cpu_dok), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_creq", 32'(c_req), 32'd0);
    check("rst_caddr", c_addr, 32'd0);
    check("rst_size", 32'(c_size), 32'd2);
    check("rst_invdone", 32'(inv_done), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Cold miss and repeat hit.
    b0 = bus_log.size();
    k0 = cpu_dok_cnt;
    fetch(32'h0000_1004, d, same, dc);
    check("cold_nbeats", bus_log.size() - b0, 32'd4);
    for (int i = 0; i < 4; i++)
      check("cold_beat", bus_log[b0 + i], 32'h1000 + 32'(4 * i));
    check("cold_rdata", d, 32'h0000_1004);
    check("cold_same", 32'(same), 32'd0);
    check("cold_dokcnt", cpu_dok_cnt - k0, 32'd1);
    b0 = bus_log.size();
    fetch(32'h0000_1004, d, same, dc);
    check("hit_same", 32'(same), 32'd1);
    check("hit_rdata", d, 32'h0000_1004);
    check("hit_nobus", bus_log.size() - b0, 32'd0);
    fetch(32'h0000_100C, d, same, dc);
    check("hit_w3", d, 32'h0000_100C);

    // Two-way conflict in set 0.
    b0 = bus_log.size();
    fetch(32'h0000_9000, d, same, dc);
    check("conf_9000_bus", bus_log.size() - b0, 32'd4);
    check("conf_9000_rd", d, 32'h0000_9000);
    fetch(32'h0000_1000, d, same, dc);
    check("conf_touch", 32'(same), 32'd1);
    b0 = bus_log.size();
    fetch(32'h0001_1000, d, same, dc);
    check("conf_11000_bus", bus_log.size() - b0, 32'd4);
    check("conf_11000_rd", d, 32'h0001_1000);
    fetch(32'h0000_1000, d, same, dc);
    check("conf_keep", 32'(same), 32'd1);
    b0 = bus_log.size();
    fetch(32'h0000_9000, d, same, dc);
    check("conf_evicted", bus_log.size() - b0, 32'd4);

    // Uncached bypass.
    b0 = bus_log.size();
    fetch(32'hBFC0_0000, d, same, dc);
    check("unc_nbus", bus_log.size() - b0, 32'd1);
    check("unc_addr", bus_log[b0], 32'hBFC0_0000);
    check("unc_rdata", d, 32'hBFC0_0000);
    check("unc_cycle", dc, last_bus_dok_cyc);
    b0 = bus_log.size();
    fetch(32'hBFC0_0000, d, same, dc);
    check("unc_again", bus_log.size() - b0, 32'd1);

    // Slow bus on every beat.
    aok_dly = 3;
    dok_dly = 5;
    run_min = 999;
    run_max = 0;
    b0 = bus_log.size();
    fetch(32'h0000_2058, d, same, dc);
    check("slow_nbeats", bus_log.size() - b0, 32'd4);
    for (int i = 0; i < 4; i++)
      check("slow_beat", bus_log[b0 + i], 32'h2050 + 32'(4 * i));
    check("slow_rdata", d, 32'h0000_2058);
    check("slow_runmin", run_min, 32'd4);
    check("slow_runmax", run_max, 32'd4);
    aok_dly = 0;
    dok_dly = 1;
    for (int i = 0; i < 4; i++) begin
      a = 32'h2050 + 32'(4 * i);
      fetch(a, d, same, dc);
      check("slot_hit", 32'(same), 32'd1);
      check("slot_data", d, a);
    end

    // Invalidate sweep, raised together with a CPU request.
    @(negedge clk);
    inv_req = 1'b1;
    cpu_req = 1'b1;
    cpu_addr = 32'h0000_1000;
    #3;
    c0 = cyc;
    check("inv_prio_aok", 32'(cpu_aok), 32'd0);
    n = 0;
    bad = 0;
    done = 1'b0;
    dc = -1;
    while (n < SETS + 20 && !done) begin
      @(negedge clk);
      #3;
      if (cpu_aok) bad++;
      if (inv_done) begin
        done = 1'b1;
        dc = cyc;
        inv_req = 1'b0;
        cpu_req = 1'b0;
      end
      n++;
    end
    inv_req = 1'b0;
    cpu_req = 1'b0;
    check("inv_seen", 32'(done), 32'd1);
    check("inv_lat", dc - c0, SETS);
    check("inv_aok", bad, 32'd0);
    @(negedge clk);
    #3;
    check("inv_pulse", 32'(inv_done), 32'd0);
    b0 = bus_log.size();
    fetch(32'h0000_1000, d, same, dc);
    check("inv_miss_1000", bus_log.size() - b0, 32'd4);
    b0 = bus_log.size();
    fetch(32'h0000_9000, d, same, dc);
    check("inv_miss_9000", bus_log.size() - b0, 32'd4);
    b0 = bus_log.size();
    fetch(32'h0000_2050, d, same, dc);
    check("inv_miss_2050", bus_log.size() - b0, 32'd4);

    // Reset during beat 2 of a refill.
    dok_dly = 2;
    b0 = bus_log.size();
    k0 = cpu_dok_cnt;
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_addr = 32'h0000_3000;
    n = 0;
    #3;
    while (n < 50 && !cpu_aok) begin
      @(negedge clk);
      #3;
      n++;
    end
    @(negedge clk);
    cpu_req = 1'b0;
    n = 0;
    #3;
    while (n < 100 && bus_log.size() < b0 + 3) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("rm_beat2", bus_log.size() - b0, 32'd3);
    @(negedge clk);
    resetn = 1'b0;
    #3;
    check("rm_req", 32'(c_req), 32'd0);
    check("rm_dok", 32'(cpu_dok), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    #4;
    check("rm_nodok", cpu_dok_cnt - k0, 32'd0);
    dok_dly = 1;
    b0 = bus_log.size();
    fetch(32'h0000_3000, d, same, dc);
    check("rm_remiss", bus_log.size() - b0, 32'd4);
    check("rm_rdata", d, 32'h0000_3000);

    check("req_while_pend", req_while_pend, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
